// File: rtl/uart_word_assembler_if.sv
// ---------------------------------------------------------------------------
// uart_word_assembler_if
// Byte-in / word-out bundle between a UART receiver and the word assembler.
//   i_rx_byte_valid : 1-cycle pulse, a byte was received
//   i_rx_byte       : received byte, valid with i_rx_byte_valid
//   i_rx_error      : 1-cycle pulse, UART framing/overrun error
//   o_word_valid    : 1-cycle pulse, o_word_data carries a new word
//   o_word_data     : assembled 32-bit word, held until the next word
//   o_resync_seen   : 1-cycle pulse, alignment word seen on the byte stream
//   o_discard       : 1-cycle pulse, a partial word was dropped
//   o_hunting       : high while alignment is unknown
// master = byte source / word sink, slave = assembler.
// ---------------------------------------------------------------------------
interface uart_word_assembler_if;
  logic        i_rx_byte_valid;
  logic [7:0]  i_rx_byte;
  logic        i_rx_error;
  logic        o_word_valid;
  logic [31:0] o_word_data;
  logic        o_resync_seen;
  logic        o_discard;
  logic        o_hunting;

  modport master (
    output i_rx_byte_valid, i_rx_byte, i_rx_error,
    input  o_word_valid, o_word_data, o_resync_seen, o_discard, o_hunting
  );

  modport slave (
    input  i_rx_byte_valid, i_rx_byte, i_rx_error,
    output o_word_valid, o_word_data, o_resync_seen, o_discard, o_hunting
  );
endinterface

// File: rtl/uart_word_assembler.sv
// ---------------------------------------------------------------------------
// uart_word_assembler
// Packs a UART byte stream into little-endian 32-bit words, re-aligns on a
// known resync word and drops partial words on UART errors.
// Optional idle timeout for partial words: define WORD_ASM_TIMEOUT_EN.
// Ports:
//   i_clk   : system clock, rising edge
//   i_reset : asynchronous, active-high reset
//   bus     : uart_word_assembler_if.slave (byte input, word output, status)
// Parameters:
//   TIMEOUT_CYCLES : idle clocks in a partial word before it is discarded
//   RESYNC_WORD    : alignment word, first byte on the wire is [7:0]
// ---------------------------------------------------------------------------
module uart_word_assembler #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter logic [31:0] RESYNC_WORD    = 32'h1EDC6F41
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  uart_word_assembler_if.slave  bus
);

  typedef enum logic [1:0] {
    sIDLE  = 2'd0,
    sACCUM = 2'd1,
    sHUNT  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [23:0] r_acc, w_acc_nxt;
  logic [31:0] r_win, w_win_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic        r_word_valid, w_word_valid_nxt;
  logic        r_resync_seen, w_resync_seen_nxt;
  logic        r_discard, w_discard_nxt;
`ifdef WORD_ASM_TIMEOUT_EN
  logic [15:0] r_cnt, w_cnt_nxt;
`endif

  logic [31:0] w_win_shift;
  logic [31:0] w_word;

  // Newest byte enters at the top so the window reads little-endian,
  // directly comparable with RESYNC_WORD.
  assign w_win_shift = {bus.i_rx_byte, r_win[31:8]};
  assign w_word      = {bus.i_rx_byte, r_acc};

  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_acc_nxt         = r_acc;
    w_win_nxt         = r_win;
    w_data_nxt        = r_data;
    w_word_valid_nxt  = 1'b0;
    w_resync_seen_nxt = 1'b0;
    w_discard_nxt     = 1'b0;
`ifdef WORD_ASM_TIMEOUT_EN
    w_cnt_nxt         = r_cnt;
`endif

    if (bus.i_rx_error) begin
      // Error wins over everything; a byte in the same cycle is dropped.
      w_state_nxt   = sHUNT;
      w_idx_nxt     = 2'd0;
      w_discard_nxt = (r_idx != 2'd0);
`ifdef WORD_ASM_TIMEOUT_EN
      w_cnt_nxt     = 16'd0;
`endif
    end else if (bus.i_rx_byte_valid) begin
      w_win_nxt = w_win_shift;
`ifdef WORD_ASM_TIMEOUT_EN
      w_cnt_nxt = 16'd0;
`endif
      if (w_win_shift == RESYNC_WORD) begin
        // Covers the aligned 4th-byte case too: a single word pulse.
        w_word_valid_nxt  = 1'b1;
        w_data_nxt        = RESYNC_WORD;
        w_resync_seen_nxt = 1'b1;
        w_idx_nxt         = 2'd0;
        w_state_nxt       = sIDLE;
      end else if (r_state != sHUNT) begin
        w_idx_nxt = r_idx + 2'd1;
        case (r_idx)
          2'd0:    w_acc_nxt[7:0]   = bus.i_rx_byte;
          2'd1:    w_acc_nxt[15:8]  = bus.i_rx_byte;
          2'd2:    w_acc_nxt[23:16] = bus.i_rx_byte;
          default: ;
        endcase
        if (r_idx == 2'd3) begin
          w_word_valid_nxt = 1'b1;
          w_data_nxt       = w_word;
          w_state_nxt      = sIDLE;
        end else begin
          w_state_nxt = sACCUM;
        end
      end
    end
`ifdef WORD_ASM_TIMEOUT_EN
    else if (r_state == sACCUM) begin
      // r_cnt holds idle clocks already seen, so this fires on the
      // TIMEOUT_CYCLES-th idle clock.
      if (r_cnt == TIMEOUT_CYCLES - 16'd1) begin
        w_discard_nxt = 1'b1;
        w_idx_nxt     = 2'd0;
        w_state_nxt   = sIDLE;
        w_cnt_nxt     = 16'd0;
      end else begin
        w_cnt_nxt = r_cnt + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= sIDLE;
      r_idx         <= 2'd0;
      r_acc         <= 24'd0;
      r_win         <= 32'd0;
      r_data        <= 32'd0;
      r_word_valid  <= 1'b0;
      r_resync_seen <= 1'b0;
      r_discard     <= 1'b0;
`ifdef WORD_ASM_TIMEOUT_EN
      r_cnt         <= 16'd0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_acc         <= w_acc_nxt;
      r_win         <= w_win_nxt;
      r_data        <= w_data_nxt;
      r_word_valid  <= w_word_valid_nxt;
      r_resync_seen <= w_resync_seen_nxt;
      r_discard     <= w_discard_nxt;
`ifdef WORD_ASM_TIMEOUT_EN
      r_cnt         <= w_cnt_nxt;
`endif
    end
  end

  assign bus.o_word_valid  = r_word_valid;
  assign bus.o_word_data   = r_data;
  assign bus.o_resync_seen = r_resync_seen;
  assign bus.o_discard     = r_discard;
  assign bus.o_hunting     = (r_state == sHUNT);

endmodule

// File: tb/tb_uart_word_assembler.sv
// ---------------------------------------------------------------------------
// tb_uart_word_assembler
// Directed scenarios plus randomized traffic against a queue-based model.
// Stimulus codes: bit9 = error pulse, bit8 = byte valid, [7:0] = byte.
// ---------------------------------------------------------------------------
module tb_uart_word_assembler;

  localparam logic [15:0] TO     = 16'd16;
  localparam logic [31:0] RESYNC = 32'h1EDC6F41;
`ifdef WORD_ASM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [9:0] IDL = 10'h000;
  localparam logic [9:0] ERR = 10'h200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  uart_word_assembler_if bus();

  uart_word_assembler #(.TIMEOUT_CYCLES(TO), .RESYNC_WORD(RESYNC)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  m_win[$];
  logic [7:0]  m_acc[4];
  int          m_cnt;
  int          m_idle;
  bit          m_hunt;
  logic [3:0]  exp_flags;   // {word_valid, resync_seen, discard, hunting}
  logic [31:0] exp_data;

  function automatic logic [9:0] V(input logic [7:0] b);
    return {2'b01, b};
  endfunction

  task automatic model_reset();
    m_win = '{8'h00, 8'h00, 8'h00, 8'h00};
    m_cnt = 0; m_idle = 0; m_hunt = 1'b0;
    exp_flags = 4'b0; exp_data = 32'h0;
  endtask

  task automatic model_step(input logic [9:0] c);
    logic wv, rs, dc;
    logic [31:0] win;
    wv = 1'b0; rs = 1'b0; dc = 1'b0;
    if (c[9]) begin
      if (!m_hunt && m_cnt > 0) dc = 1'b1;
      m_hunt = 1'b1; m_cnt = 0; m_idle = 0;
    end else if (c[8]) begin
      m_idle = 0;
      m_win.push_back(c[7:0]);
      void'(m_win.pop_front());
      win = {m_win[3], m_win[2], m_win[1], m_win[0]};
      if (win == RESYNC) begin
        wv = 1'b1; rs = 1'b1; exp_data = RESYNC; m_hunt = 1'b0; m_cnt = 0;
      end else if (!m_hunt) begin
        m_acc[m_cnt] = c[7:0];
        m_cnt++;
        if (m_cnt == 4) begin
          wv = 1'b1; exp_data = {m_acc[3], m_acc[2], m_acc[1], m_acc[0]};
          m_cnt = 0;
        end
      end
    end else if (TO_EN && !m_hunt && m_cnt > 0) begin
      m_idle++;
      if (m_idle == int'(TO)) begin
        dc = 1'b1; m_cnt = 0; m_idle = 0;
      end
    end
    exp_flags = {wv, rs, dc, m_hunt};
  endtask

  // Drive one clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic [9:0] c);
    bus.i_rx_error      = c[9];
    bus.i_rx_byte_valid = c[8];
    bus.i_rx_byte       = c[7:0];
    model_step(c);
    @(posedge clk);
    #1;
    bus.i_rx_error      = 1'b0;
    bus.i_rx_byte_valid = 1'b0;
    bus.i_rx_byte       = 8'h00;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [3:0] flags();
    return {bus.o_word_valid, bus.o_resync_seen, bus.o_discard, bus.o_hunting};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #3;
    checks++;
    if ({flags(), bus.o_word_data} !== 36'h0) begin
      errors++;
      $display("FAIL reset_state got flags=%b data=%h want 0", flags(), bus.o_word_data);
    end
    apply_reset();
  endtask

  task automatic test_word();
    logic [9:0] s[6];
    int nw;
    s = '{V(8'h78), V(8'h56), V(8'h34), V(8'h12), IDL, IDL};
    nw = 0;
    apply_reset();
    foreach (s[i]) begin
      step(s[i]);
      if (bus.o_word_valid) nw++;
      checks++;
      if (flags() !== exp_flags) begin
        errors++; $display("FAIL word_flags step%0d got %b want %b", i, flags(), exp_flags);
      end
      checks++;
      if (bus.o_word_data !== exp_data) begin
        errors++; $display("FAIL word_data step%0d got %h want %h", i, bus.o_word_data, exp_data);
      end
      if (i == 3) begin
        checks++;
        if (bus.o_word_valid !== 1'b1 || bus.o_word_data !== 32'h12345678) begin
          errors++; $display("FAIL word_latency got v=%b d=%h want 1/12345678", bus.o_word_valid, bus.o_word_data);
        end
      end
    end
    checks++;
    if (nw != 1) begin errors++; $display("FAIL word_count got %0d want 1", nw); end
  endtask

  task automatic test_resync();
    logic [9:0] s[11];
    int nw, nr;
    s = '{ERR, V(8'hAA), V(8'h41), V(8'h6F), V(8'hDC), V(8'h1E),
          V(8'h01), V(8'h02), V(8'h03), V(8'h04), IDL};
    nw = 0; nr = 0;
    apply_reset();
    foreach (s[i]) begin
      step(s[i]);
      if (bus.o_word_valid) nw++;
      if (bus.o_resync_seen) nr++;
      checks++;
      if (flags() !== exp_flags) begin
        errors++; $display("FAIL resync_flags step%0d got %b want %b", i, flags(), exp_flags);
      end
      checks++;
      if (bus.o_word_data !== exp_data) begin
        errors++; $display("FAIL resync_data step%0d got %h want %h", i, bus.o_word_data, exp_data);
      end
    end
    checks++;
    if (nw != 2 || nr != 1 || bus.o_word_data !== 32'h04030201) begin
      errors++; $display("FAIL resync_summary got words=%0d resyncs=%0d data=%h want 2/1/04030201", nw, nr, bus.o_word_data);
    end
  endtask

  task automatic test_aligned_resync();
    logic [9:0] s[5];
    int nw, nr;
    s = '{V(8'h41), V(8'h6F), V(8'hDC), V(8'h1E), IDL};
    nw = 0; nr = 0;
    apply_reset();
    foreach (s[i]) begin
      step(s[i]);
      if (bus.o_word_valid) nw++;
      if (bus.o_resync_seen) nr++;
      checks++;
      if ({flags(), bus.o_word_data} !== {exp_flags, exp_data}) begin
        errors++; $display("FAIL aligned_resync step%0d got %b/%h want %b/%h", i, flags(), bus.o_word_data, exp_flags, exp_data);
      end
    end
    checks++;
    if (nw != 1 || nr != 1) begin
      errors++; $display("FAIL aligned_resync_count got words=%0d resyncs=%0d want 1/1", nw, nr);
    end
  endtask

  task automatic test_error_hunt();
    logic [9:0] s[12];
    int nw, nd;
    s = '{V(8'h01), V(8'h02), ERR, V(8'h11), V(8'h22), V(8'h33), V(8'h44),
          V(8'h41), V(8'h6F), V(8'hDC), V(8'h1E), IDL};
    nw = 0; nd = 0;
    apply_reset();
    foreach (s[i]) begin
      step(s[i]);
      if (bus.o_word_valid) nw++;
      if (bus.o_discard) nd++;
      checks++;
      if ({flags(), bus.o_word_data} !== {exp_flags, exp_data}) begin
        errors++; $display("FAIL error_hunt step%0d got %b/%h want %b/%h", i, flags(), bus.o_word_data, exp_flags, exp_data);
      end
      if (i == 6) begin
        checks++;
        if (bus.o_hunting !== 1'b1) begin
          errors++; $display("FAIL hunt_hold got %b want 1", bus.o_hunting);
        end
      end
    end
    checks++;
    if (nw != 1 || nd != 1 || bus.o_hunting !== 1'b0 || bus.o_word_data !== RESYNC) begin
      errors++; $display("FAIL error_hunt_summary got words=%0d discards=%0d hunt=%b data=%h want 1/1/0/1edc6f41", nw, nd, bus.o_hunting, bus.o_word_data);
    end
  endtask

  task automatic test_timeout();
    int nd;
    logic [31:0] want;
    want = TO_EN ? 32'h04030201 : 32'h03020155;
    nd = 0;
    apply_reset();
    for (int i = 0; i < 23; i++) begin
      if (i == 0) step(V(8'h55));
      else if (i >= 17 && i <= 20) step(V(8'(i - 16)));
      else step(IDL);
      if (bus.o_discard) nd++;
      checks++;
      if ({flags(), bus.o_word_data} !== {exp_flags, exp_data}) begin
        errors++; $display("FAIL timeout step%0d got %b/%h want %b/%h", i, flags(), bus.o_word_data, exp_flags, exp_data);
      end
    end
    checks++;
    if (nd != (TO_EN ? 1 : 0) || bus.o_word_data !== want) begin
      errors++; $display("FAIL timeout_summary got discards=%0d data=%h want %0d/%h", nd, bus.o_word_data, TO_EN ? 1 : 0, want);
    end
  endtask

  task automatic test_reset_midword();
    logic [9:0] s[6];
    int nd;
    s = '{V(8'hAA), V(8'hBB), V(8'hCC), V(8'hDD), V(8'h01), V(8'h02)};
    foreach (s[i]) step(s[i]);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({flags(), bus.o_word_data} !== 36'h0) begin
      errors++; $display("FAIL reset_async got flags=%b data=%h want 0", flags(), bus.o_word_data);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      step(i < 4 ? V(8'(i + 1)) : IDL);
      if (bus.o_discard) nd++;
      checks++;
      if ({flags(), bus.o_word_data} !== {exp_flags, exp_data}) begin
        errors++; $display("FAIL reset_midword step%0d got %b/%h want %b/%h", i, flags(), bus.o_word_data, exp_flags, exp_data);
      end
    end
    checks++;
    if (nd != 0 || bus.o_word_data !== 32'h04030201) begin
      errors++; $display("FAIL reset_midword_summary got discards=%0d data=%h want 0/04030201", nd, bus.o_word_data);
    end
  endtask

  task automatic test_random();
    int r;
    logic [9:0] c;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 5) c = ERR | (($urandom_range(0, 1) == 1) ? V(8'($urandom)) : IDL);
      else if (r < 60) c = V(8'($urandom));
      else c = IDL;
      if (r >= 95) begin
        // insert the alignment word on the stream
        for (int k = 0; k < 4; k++) begin
          step(V(RESYNC[8*k +: 8]));
          checks++;
          if ({flags(), bus.o_word_data} !== {exp_flags, exp_data}) begin
            errors++; $display("FAIL random_resync n%0d got %b/%h want %b/%h", n, flags(), bus.o_word_data, exp_flags, exp_data);
          end
        end
      end else begin
        for (int k = 0; k < ((r >= 90) ? 18 : 1); k++) begin
          step((k == 0) ? c : IDL);
          checks++;
          if ({flags(), bus.o_word_data} !== {exp_flags, exp_data}) begin
            errors++; $display("FAIL random n%0d.%0d got %b/%h want %b/%h", n, k, flags(), bus.o_word_data, exp_flags, exp_data);
          end
        end
      end
    end
  endtask

  initial begin
    bus.i_rx_byte_valid = 1'b0;
    bus.i_rx_byte       = 8'h00;
    bus.i_rx_error      = 1'b0;
    model_reset();
    test_reset();
    test_word();
    test_resync();
    test_aligned_resync();
    test_error_hunt();
    test_timeout();
    test_reset_midword();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_word_assembler.md
UART_WORD_ASSEMBLER -- requirements
Module: uart_word_assembler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000, idle clocks before a partial word is discarded.
REQ-002 SHALL have parameter RESYNC_WORD, default 32'h1EDC6F41, alignment word; byte 0 is [7:0].
REQ-003 SHALL have port i_clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_rx_byte_valid  input  1  one-cycle pulse, UART byte received.
REQ-006 SHALL have port i_rx_byte  input  8  received byte, valid with i_rx_byte_valid.
REQ-007 SHALL have port i_rx_error  input  1  one-cycle pulse, UART framing/overrun error.
REQ-008 SHALL have port o_word_valid  output  1  one-cycle pulse, o_word_data valid; drives packet decoder word command input.
REQ-009 SHALL have port o_word_data  output  32  assembled word, held until next word.
REQ-010 SHALL have port o_resync_seen  output  1  one-cycle pulse when RESYNC_WORD is detected on the byte stream.
REQ-011 SHALL have port o_discard  output  1  one-cycle pulse when a partial word is dropped.
REQ-012 SHALL have port o_hunting  output  1  high while in sHUNT.

Function
REQ-013 SHALL assemble bytes little-endian: nth byte of a word (n=0..3) into bits [8n+7:8n].
REQ-014 SHALL keep a 2-bit byte index; index wraps 3->0 on the 4th byte.
REQ-015 SHALL assert o_word_valid and update o_word_data on the clock edge after the 4th byte's i_rx_byte_valid cycle (latency 1 cycle).
REQ-016 SHALL keep a 32-bit sliding window of the last four bytes, updated on every valid byte in every state.
REQ-017 SHALL have states sIDLE (index 0), sACCUM (index 1-3), sHUNT (alignment unknown).
REQ-018 SHALL transition sIDLE->sACCUM on valid byte; sACCUM->sIDLE on 4th byte; sACCUM->sIDLE on timeout; any->sHUNT on i_rx_error.
REQ-019 SHALL, when the window equals RESYNC_WORD in any state, emit o_word_valid with o_word_data=RESYNC_WORD, pulse o_resync_seen, set index 0, enter sIDLE.
REQ-020 SHALL emit exactly one o_word_valid when the resync match coincides with an aligned 4th byte.
REQ-021 SHALL suppress all word output in sHUNT except a resync match per REQ-019.
REQ-022 SHALL apply priority i_rx_error > resync match > normal byte > timeout; a byte coinciding with i_rx_error is dropped.
REQ-023 SHALL pulse o_discard when i_rx_error arrives with index 1-3, or on timeout.
REQ-024 SHALL count idle clocks in sACCUM with a 16-bit counter, cleared on each valid byte; timeout fires when count reaches TIMEOUT_CYCLES-1.
REQ-025 SHALL keep o_word_valid, o_resync_seen, o_discard registered, never combinational.

Reset
REQ-026 SHALL on i_reset force sIDLE, index 0, window 0, timeout counter 0, o_word_data 0, o_word_valid/o_resync_seen/o_discard/o_hunting 0.
REQ-027 SHALL drop any partial word on reset mid-word without pulsing o_discard.

Configuration
REQ-028 SHALL, with WORD_ASM_TIMEOUT_EN defined, implement REQ-024 and the timeout transition of REQ-018.
REQ-029 SHALL, without WORD_ASM_TIMEOUT_EN, omit the counter; partial words are held indefinitely, dropped only by error or resync.

Verification
REQ-030 Bytes 0x78,0x56,0x34,0x12 -> one o_word_valid, o_word_data=0x12345678, one cycle after 4th byte.
REQ-031 Bytes 0xAA,0x41,0x6F,0xDC,0x1E -> one o_word_valid with 0x1EDC6F41, o_resync_seen pulse, next 4 bytes form an aligned word.
REQ-032 Bytes 0x01,0x02 then i_rx_error -> o_discard pulse, o_hunting=1; bytes 0x11,0x22,0x33,0x44 -> no word; then 0x41,0x6F,0xDC,0x1E -> word 0x1EDC6F41, o_hunting=0.
REQ-033 TIMEOUT_CYCLES=16, byte 0x55 then 16 idle clocks -> o_discard pulse, sIDLE; next 0x01,0x02,0x03,0x04 -> word 0x04030201 (macro defined); without macro -> word 0x03020155.
REQ-034 i_reset asserted after 2 bytes -> all outputs 0 immediately; next 4 bytes 0x01..0x04 -> word 0x04030201.
